// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic int num_digits(input int width, input int digit_bits);
    return width / digit_bits;
  endfunction

  // One spare bit so the counter can hold N itself without wrapping.
  function automatic int cnt_width(input int width, input int digit_bits);
    return $clog2(num_digits(width, digit_bits)) + 1;
  endfunction

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: d = x - y, bout set when x < y.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bout
);

  assign d    = x ^ y;
  assign bout = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor with valid/ready handshakes on both sides.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DIGIT_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int N     = num_digits(WIDTH, DIGIT_BITS);
  localparam int CNT_W = cnt_width(WIDTH, DIGIT_BITS);

  if (DIGIT_BITS < 1 || (WIDTH % DIGIT_BITS) != 0) begin : g_bad_cfg
    $error("serial_subtractor: DIGIT_BITS must divide WIDTH");
  end

  state_e                state, next_state;
  logic [CNT_W-1:0]      cnt;
  logic [WIDTH-1:0]      a_sh, b_sh, diff_next;
  logic                  bflop;
  logic [DIGIT_BITS-1:0] dig;
  logic [DIGIT_BITS:0]   chain;
  logic                  last;

  // Ripple borrow through the current digit: two half subtractors per bit.
  assign chain[0] = bflop;
  for (genvar i = 0; i < DIGIT_BITS; i++) begin : g_bit
    logic d1, b1, b2;
    half_subtractor u_hs_ab (.x(a_sh[i]), .y(b_sh[i]),   .d(d1),     .bout(b1));
    half_subtractor u_hs_bi (.x(d1),      .y(chain[i]), .d(dig[i]), .bout(b2));
    assign chain[i+1] = b1 | b2;
  end

  if (DIGIT_BITS == WIDTH) begin : g_single
    assign diff_next = dig;
  end else begin : g_multi
    assign diff_next = {dig, diff[WIDTH-1:DIGIT_BITS]};
  end

  assign last = (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = BUSY;
      end
      BUSY: if (last) next_state = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb, b_msb;
`endif

  // Results only change in BUSY, so they hold through DONE and the following IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      bflop    <= 1'b0;
      cnt      <= '0;
      diff     <= '0;
      borrow   <= 1'b0;
      zero     <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh  <= a;
          b_sh  <= b;
          bflop <= 1'b0;
          cnt   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          a_msb <= a[WIDTH-1];
          b_msb <= b[WIDTH-1];
`endif
        end
        BUSY: begin
          a_sh  <= a_sh >> DIGIT_BITS;
          b_sh  <= b_sh >> DIGIT_BITS;
          diff  <= diff_next;
          bflop <= chain[DIGIT_BITS];
          cnt   <= cnt + 1'b1;
          if (last) begin
            borrow   <= chain[DIGIT_BITS];
            zero     <= (diff_next == '0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            overflow <= (a_msb != b_msb) && (diff_next[WIDTH-1] != a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench: an 8-bit/1-bit-digit DUT and a 32-bit/4-bit-digit DUT.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [7:0]  a, b, diff;
  logic        borrow, zero, overflow;

  logic        w_in_valid, w_out_ready;
  logic        w_in_ready, w_out_valid;
  logic [31:0] w_a, w_b, w_diff;
  logic        w_borrow, w_zero, w_overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .zero(zero)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .overflow(overflow)
`endif
  );

  serial_subtractor #(.WIDTH(32), .DIGIT_BITS(4)) dut_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .diff(w_diff), .borrow(w_borrow), .zero(w_zero)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .overflow(w_overflow)
`endif
  );

`ifndef SERIAL_SUBTRACTOR_OVF_EN
  assign overflow   = 1'b0;
  assign w_overflow = 1'b0;
`endif

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full 8-bit transaction: optional idle gap, accept, latency, results, stall, release.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb_op,
                               input int gap, input int hold, input bit poke);
    logic [7:0] ed;
    logic       eb, ez, eo;
    int         sd, lat, guard;
    ed = ta - tb_op;
    eb = (ta < tb_op);
    ez = (ed == 8'd0);
    sd = int'($signed(ta)) - int'($signed(tb_op));
    eo = (sd > 127) || (sd < -128);
    repeat (gap) begin @(posedge clk); #1; end
    a = ta; b = tb_op; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!in_ready) begin
      checkOutput("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    checkOutput("latency", 64'(lat), 64'd9);
    checkOutput("diff", 64'(diff), 64'(ed));
    checkOutput("borrow", 64'(borrow), 64'(eb));
    checkOutput("zero", 64'(zero), 64'(ez));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    checkOutput("overflow", 64'(overflow), 64'(eo));
`endif
    checkOutput("in_ready_done", 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); end
      @(posedge clk); #1;
      checkOutput("stall_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_diff", 64'(diff), 64'(ed));
      checkOutput("stall_zero", 64'(zero), 64'(ez));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("post_valid", 64'(out_valid), 64'd0);
    checkOutput("post_ready", 64'(in_ready), 64'd1);
    checkOutput("post_diff", 64'(diff), 64'(ed));
    checkOutput("post_borrow", 64'(borrow), 64'(eb));
  endtask

  task automatic applyWideStimulus(input logic [31:0] ta, input logic [31:0] tb_op);
    logic [31:0] ed;
    logic        eo;
    longint      sd;
    int          lat, guard;
    ed = ta - tb_op;
    sd = longint'($signed(ta)) - longint'($signed(tb_op));
    eo = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    w_a = ta; w_b = tb_op; w_in_valid = 1'b1;
    guard = 0;
    while (!w_in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    w_in_valid = 1'b0; w_a = $urandom; w_b = $urandom;
    lat = 1;
    while (!w_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    checkOutput("w_latency", 64'(lat), 64'd9);
    checkOutput("w_diff", 64'(w_diff), 64'(ed));
    checkOutput("w_borrow", 64'(w_borrow), 64'(ta < tb_op));
    checkOutput("w_zero", 64'(w_zero), 64'(ed == 32'd0));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    checkOutput("w_overflow", 64'(w_overflow), 64'(eo));
`endif
    @(posedge clk); #1;
    checkOutput("w_post_valid", 64'(w_out_valid), 64'd0);
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [31:0] wa, wb;
    bit          seen_valid;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_a = '0; w_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_diff", 64'(diff), 64'd0);
    checkOutput("rst_borrow", 64'(borrow), 64'd0);
    checkOutput("rst_zero", 64'(zero), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_w_in_ready", 64'(w_in_ready), 64'd1);

    applyStimulus(8'd100, 8'd58, 0, 0, 1'b0);
    applyStimulus(8'd5, 8'd7, 1, 0, 1'b0);
    applyStimulus(8'h80, 8'h01, 0, 2, 1'b0);
    applyStimulus(8'd0, 8'd1, 0, 0, 1'b0);
    applyStimulus(8'hFF, 8'd0, 2, 1, 1'b0);
    applyStimulus(8'hA5, 8'hA5, 0, 20, 1'b1);

    // Reset in the middle of an operation must discard it.
    a = 8'd200; b = 8'd13; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_diff", 64'(diff), 64'd0);
    checkOutput("mid_rst_borrow", 64'(borrow), 64'd0);
    checkOutput("mid_rst_zero", 64'(zero), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) seen_valid = 1'b1; end
    checkOutput("no_valid_after_rst", 64'(seen_valid), 64'd0);
    applyStimulus(8'd3, 8'd1, 0, 0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
      applyStimulus(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    applyWideStimulus(32'h0000_0000, 32'h0000_0001);
    applyWideStimulus(32'hFFFF_FFFF, 32'h0000_0000);
    applyWideStimulus(32'h1234_5678, 32'h1234_5678);
    applyWideStimulus(32'h8000_0000, 32'h0000_0001);
    for (int n = 0; n < 200; n++) begin
      wa = $urandom;
      wb = ($urandom_range(0, 7) == 0) ? wa : $urandom;
      applyWideStimulus(wa, wb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
